// File: rtl/risc8_uart_pkg.sv
// Shared encodings for the RISC8 UART arbiter slice: serializer states,
// last-grant owner encoding and the default baud divisor.
package risc8_uart_pkg;

   localparam int unsigned DIVISOR_DEFAULT = 52;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic LG_A = 1'b0;
   localparam logic LG_B = 1'b1;

endpackage

// File: rtl/risc8_uart_tx.sv
// 8N1 serializer: accepts a byte on load while idle, then shifts out
// start, eight data bits LSB first and stop, DIVISOR clocks per bit.
module risc8_uart_tx
   import risc8_uart_pkg::*;
#(
   parameter int unsigned DIVISOR = DIVISOR_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic       serial_tx
);

   localparam logic [15:0] BAUD_LOAD = 16'(DIVISOR - 1);

   logic [1:0]  state_r;
   logic [15:0] cnt_r;
   logic [2:0]  bit_r;
   logic [7:0]  shift_r;
   logic        tx_r;
   logic        busy_r;

   // Frame sequencer: every state or bit entry reloads the baud counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 16'd0;
         bit_r   <= 3'd0;
         shift_r <= 8'd0;
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (load) begin
                  shift_r <= data;
                  cnt_r   <= BAUD_LOAD;
                  bit_r   <= 3'd0;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
                  state_r <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_r == 16'd0) begin
                  cnt_r   <= BAUD_LOAD;
                  tx_r    <= shift_r[0];
                  state_r <= ST_DATA;
               end else begin
                  cnt_r <= cnt_r - 16'd1;
               end
            end
            ST_DATA: begin
               if (cnt_r == 16'd0) begin
                  cnt_r <= BAUD_LOAD;
                  bit_r <= bit_r + 3'd1;
                  if (bit_r == 3'd7) begin
                     tx_r    <= 1'b1;
                     state_r <= ST_STOP;
                  end else begin
                     tx_r    <= shift_r[1];
                     shift_r <= {1'b0, shift_r[7:1]};
                  end
               end else begin
                  cnt_r <= cnt_r - 16'd1;
               end
            end
            ST_STOP: begin
               if (cnt_r == 16'd0) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r - 16'd1;
               end
            end
            default: begin
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = (state_r == ST_STOP) && (cnt_r == 16'd0);
   assign serial_tx = tx_r;

endmodule

// File: rtl/risc8_uart_arb.sv
// Two-requester byte arbiter (round-robin with owner lock) in front of
// a shared 8N1 UART transmitter.
module risc8_uart_arb
   import risc8_uart_pkg::*;
#(
   parameter int unsigned DIVISOR = DIVISOR_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_valid,
   input  logic [7:0] a_data,
   input  logic       a_lock,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic [7:0] b_data,
   input  logic       b_lock,
   output logic       b_ready,
   output logic       serial_tx,
   output logic       busy,
   output logic       grant_a,
   output logic       grant_b
);

   logic       last_grant_r;
   logic       grant_a_r;
   logic       grant_b_r;
   logic       pick_a_s;
   logic       pick_b_s;
   logic       load_s;
   logic [7:0] load_data_s;
   logic       tx_busy_s;
   logic       tx_done_s;

   // Winner select: a locked previous owner keeps the line, otherwise ties alternate.
   always_comb begin
      pick_a_s = 1'b0;
      pick_b_s = 1'b0;
      if (!reset || tx_busy_s) begin
         pick_a_s = 1'b0;
         pick_b_s = 1'b0;
      end else if ((last_grant_r == LG_A) && a_lock && a_valid) begin
         pick_a_s = 1'b1;
      end else if ((last_grant_r == LG_B) && b_lock && b_valid) begin
         pick_b_s = 1'b1;
      end else if (a_valid && b_valid) begin
         pick_a_s = (last_grant_r == LG_B);
         pick_b_s = (last_grant_r == LG_A);
      end else begin
         pick_a_s = a_valid;
         pick_b_s = b_valid;
      end
   end

   assign load_s      = pick_a_s | pick_b_s;
   assign load_data_s = pick_b_s ? b_data : a_data;

   // Owner bookkeeping: grants cover exactly the frame, last_grant only moves on a transfer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant_r <= LG_B;
         grant_a_r    <= 1'b0;
         grant_b_r    <= 1'b0;
      end else if (load_s) begin
         last_grant_r <= pick_b_s ? LG_B : LG_A;
         grant_a_r    <= pick_a_s;
         grant_b_r    <= pick_b_s;
      end else if (tx_done_s) begin
         grant_a_r <= 1'b0;
         grant_b_r <= 1'b0;
      end
   end

   risc8_uart_tx #(
      .DIVISOR (DIVISOR)
   ) u_tx (
      .clk       (clk),
      .reset     (reset),
      .load      (load_s),
      .data      (load_data_s),
      .busy      (tx_busy_s),
      .done      (tx_done_s),
      .serial_tx (serial_tx)
   );

   assign a_ready = pick_a_s;
   assign b_ready = pick_b_s;
   assign busy    = tx_busy_s;
   assign grant_a = grant_a_r;
   assign grant_b = grant_b_r;

endmodule

// File: tb/tb_risc8_uart_arb.sv
// Bench for risc8_uart_arb: DIVISOR=4 main instance plus a DIVISOR=1 instance.
module tb_risc8_uart_arb;

   localparam int D = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int t_last = 0;

   logic       reset;
   logic       a_valid, a_lock, b_valid, b_lock;
   logic [7:0] a_data, b_data;
   logic       a_ready, b_ready, serial_tx, busy, grant_a, grant_b;

   logic       a1_valid, a1_lock, b1_valid, b1_lock;
   logic [7:0] a1_data, b1_data;
   logic       a1_ready, b1_ready, serial_tx1, busy1, grant_a1, grant_b1;

   risc8_uart_arb #(.DIVISOR(D)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_data(a_data), .a_lock(a_lock), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_lock(b_lock), .b_ready(b_ready),
      .serial_tx(serial_tx), .busy(busy), .grant_a(grant_a), .grant_b(grant_b)
   );

   risc8_uart_arb #(.DIVISOR(1)) dut1 (
      .clk(clk), .reset(reset),
      .a_valid(a1_valid), .a_data(a1_data), .a_lock(a1_lock), .a_ready(a1_ready),
      .b_valid(b1_valid), .b_data(b1_data), .b_lock(b1_lock), .b_ready(b1_ready),
      .serial_tx(serial_tx1), .busy(busy1), .grant_a(grant_a1), .grant_b(grant_b1)
   );

   // Reference line level for frame position idx (0 start, 1..8 data LSB first, 9 stop).
   function automatic logic exp_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      else if (idx == 9) return 1'b1;
      else return d[idx-1];
   endfunction

   function automatic logic [63:0] exp_wave(input logic [7:0] d, input int div);
      logic [63:0] w;
      w = 64'd0;
      for (int j = 0; j < 10 * div; j++) w[j] = exp_bit(d, j / div);
      return w;
   endfunction

   // Samples n consecutive cycles starting at the current sample point.
   task automatic capture(input int n, input bit sel, input bit jitter,
                          output logic [63:0] wave, output int busy_hi, output int ready_hi);
      wave = 64'd0; busy_hi = 0; ready_hi = 0;
      for (int j = 0; j < n; j++) begin
         wave[j] = sel ? serial_tx1 : serial_tx;
         if (sel ? busy1 : busy) busy_hi++;
         if (sel ? a1_ready : (a_ready | b_ready)) ready_hi++;
         if (jitter) begin
            if (j == n - 1) begin
               a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
            end else begin
               a_valid = 1'($urandom_range(0, 1)); b_valid = 1'($urandom_range(0, 1));
               a_lock  = 1'($urandom_range(0, 1)); b_lock  = 1'($urandom_range(0, 1));
               a_data  = 8'($urandom); b_data = 8'($urandom);
            end
         end
         if (j < n - 1) begin @(negedge clk); #1; end
      end
   endtask

   // Offers one byte on A or B, waits (bounded) for ready, ends at the first frame cycle.
   task automatic start_byte(input bit use_b, input logic [7:0] d, output bit ok);
      ok = 1'b0;
      if (use_b) begin b_valid = 1'b1; b_data = d; end
      else begin a_valid = 1'b1; a_data = d; end
      #1;
      for (int k = 0; k < 200 && !ok; k++) begin
         if (use_b ? b_ready : a_ready) ok = 1'b1;
         else begin @(negedge clk); #1; end
      end
      t_last = cyc;
      @(negedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
      repeat (3) @(negedge clk);
      #1; reset = 1'b1;
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({serial_tx, busy, grant_a, grant_b, a_ready, b_ready} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_state got=%b want=100000",
                  {serial_tx, busy, grant_a, grant_b, a_ready, b_ready});
      end
      checks++;
      if ({serial_tx1, busy1, grant_a1, grant_b1, a1_ready, b1_ready} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_state_div1 got=%b want=100000",
                  {serial_tx1, busy1, grant_a1, grant_b1, a1_ready, b1_ready});
      end
      a_valid = 1'b0; b_valid = 1'b0; reset = 1'b1;
      @(negedge clk); #1;
   endtask

   task automatic test_single_55();
      logic [63:0] w; int bh, rh;
      a_valid = 1'b1; a_data = 8'h55; #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b10) begin
         errors++; $display("FAIL single_ready got=%b want=10", {a_ready, b_ready});
      end
      @(negedge clk); #1; a_valid = 1'b0;
      checks++;
      if ({grant_a, grant_b, serial_tx} !== 3'b100) begin
         errors++; $display("FAIL single_grant_start got=%b want=100", {grant_a, grant_b, serial_tx});
      end
      capture(10 * D, 1'b0, 1'b1, w, bh, rh);
      checks++;
      if (w !== exp_wave(8'h55, D)) begin
         errors++; $display("FAIL single_wave got=%h want=%h", w, exp_wave(8'h55, D));
      end
      checks++;
      if (bh !== 10 * D || rh !== 0) begin
         errors++; $display("FAIL single_busy_ready got busy=%0d ready=%0d want busy=%0d ready=0", bh, rh, 10 * D);
      end
      @(negedge clk); #1;
      checks++;
      if ({busy, grant_a, grant_b, serial_tx} !== 4'b0001) begin
         errors++; $display("FAIL single_idle got=%b want=0001", {busy, grant_a, grant_b, serial_tx});
      end
   endtask

   task automatic test_random_frames();
      logic [63:0] w; int bh, rh; bit ok, use_b; logic [7:0] d;
      for (int i = 0; i < 4; i++) begin
         use_b = 1'($urandom_range(0, 1)); d = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         #1;
         start_byte(use_b, d, ok);
         checks++;
         if (!ok || {grant_a, grant_b} !== (use_b ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL rand_grant[%0d] ok=%0d got=%b want=%b", i, ok, {grant_a, grant_b}, use_b ? 2'b01 : 2'b10);
         end
         capture(10 * D, 1'b0, 1'b1, w, bh, rh);
         checks++;
         if (w !== exp_wave(d, D) || bh !== 10 * D || rh !== 0) begin
            errors++; $display("FAIL rand_frame[%0d] got=%h busy=%0d ready=%0d want=%h busy=%0d", i, w, bh, rh, exp_wave(d, D), 10 * D);
         end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_tie();
      logic [63:0] w; int bh, rh; int ta, tb; bit found;
      do_reset();
      a_valid = 1'b1; a_data = 8'h01; b_valid = 1'b1; b_data = 8'h02; #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b10) begin
         errors++; $display("FAIL tie_first got=%b want=10", {a_ready, b_ready});
      end
      ta = cyc;
      @(negedge clk); #1; a_valid = 1'b0; #1;
      found = 1'b0; tb = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         if (b_ready) begin found = 1'b1; tb = cyc; end
         else begin @(negedge clk); #1; end
      end
      checks++;
      if (!found || tb - ta !== 10 * D + 1) begin
         errors++; $display("FAIL tie_spacing found=%0d got=%0d want=%0d", found, tb - ta, 10 * D + 1);
      end
      @(negedge clk); #1; b_valid = 1'b0;
      capture(10 * D, 1'b0, 1'b0, w, bh, rh);
      checks++;
      if (w !== exp_wave(8'h02, D) || {grant_a, grant_b} !== 2'b01) begin
         errors++; $display("FAIL tie_b_frame got=%h grants=%b want=%h grants=01", w, {grant_a, grant_b}, exp_wave(8'h02, D));
      end
      @(negedge clk); #1;
   endtask

   task automatic test_stream(input bit lock_a, input bit lock_b, input int na, input int nb);
      logic [7:0] qa[$]; logic [7:0] qb[$];
      logic [15:0] exp_seq, got_seq;
      int exp_n, got_n, ia, ib, t_prev, bad_gap, both_rdy;
      bit last_b, va, vb, win_b;
      for (int i = 0; i < na; i++) qa.push_back(8'($urandom));
      for (int i = 0; i < nb; i++) qb.push_back(8'($urandom));
      ia = 0; ib = 0; last_b = 1'b1; exp_n = 0; exp_seq = 16'd0;
      while (ia < na || ib < nb) begin
         va = (ia < na); vb = (ib < nb);
         if (!last_b && lock_a && va) win_b = 1'b0;
         else if (last_b && lock_b && vb) win_b = 1'b1;
         else if (va && vb) win_b = !last_b;
         else win_b = vb;
         exp_seq[exp_n] = win_b; exp_n++;
         if (win_b) ib++; else ia++;
         last_b = win_b;
      end
      do_reset();
      ia = 0; ib = 0; got_n = 0; got_seq = 16'd0; t_prev = 0; bad_gap = 0; both_rdy = 0;
      for (int k = 0; k < 3000 && (ia < na || ib < nb); k++) begin
         a_valid = (ia < na); a_data = (ia < na) ? qa[ia] : 8'h00; a_lock = lock_a;
         b_valid = (ib < nb); b_data = (ib < nb) ? qb[ib] : 8'h00; b_lock = lock_b;
         #1;
         if (a_ready && b_ready) both_rdy++;
         if ((a_valid && a_ready) || (b_valid && b_ready)) begin
            if (got_n > 0 && cyc - t_prev != 10 * D + 1) bad_gap++;
            t_prev = cyc;
            got_seq[got_n] = (b_valid && b_ready);
            if (b_valid && b_ready) ib++; else ia++;
            got_n++;
         end
         @(negedge clk); #1;
      end
      a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
      checks++;
      if (got_n !== exp_n || got_seq !== exp_seq) begin
         errors++; $display("FAIL stream_order lock=%0d%0d got n=%0d seq=%b want n=%0d seq=%b", lock_a, lock_b, got_n, got_seq, exp_n, exp_seq);
      end
      checks++;
      if (bad_gap !== 0 || both_rdy !== 0) begin
         errors++; $display("FAIL stream_timing got bad_gap=%0d both_ready=%0d want 0 0", bad_gap, both_rdy);
      end
      repeat (10 * D + 2) @(negedge clk);
      #1;
   endtask

   task automatic test_valid_drop();
      logic [63:0] w; int bh, rh; bit ok; logic [7:0] d;
      do_reset();
      d = 8'($urandom);
      start_byte(1'b0, d, ok);
      capture(10 * D, 1'b0, 1'b1, w, bh, rh);
      checks++;
      if (!ok || w !== exp_wave(d, D) || rh !== 0) begin
         errors++; $display("FAIL drop_frame ok=%0d got=%h ready=%0d want=%h ready=0", ok, w, rh, exp_wave(d, D));
      end
      @(negedge clk); #1;
      a_valid = 1'b1; b_valid = 1'b1; #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b01) begin
         errors++; $display("FAIL drop_last_grant got=%b want=01", {a_ready, b_ready});
      end
      @(negedge clk); #1; a_valid = 1'b0; b_valid = 1'b0;
      repeat (10 * D + 1) @(negedge clk);
      #1;
   endtask

   task automatic test_reset_midframe();
      logic [63:0] w; int bh, rh, low_cnt, busy_cnt; bit ok;
      start_byte(1'b0, 8'h00, ok);
      capture(17, 1'b0, 1'b0, w, bh, rh);
      checks++;
      if (!ok || w[16:0] !== 17'd0 || bh !== 17) begin
         errors++; $display("FAIL abort_prefix ok=%0d got=%h busy=%0d want 0 busy=17", ok, w[16:0], bh);
      end
      reset = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({serial_tx, busy, grant_a, grant_b} !== 4'b1000) begin
         errors++; $display("FAIL abort_state got=%b want=1000", {serial_tx, busy, grant_a, grant_b});
      end
      reset = 1'b1;
      low_cnt = 0; busy_cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk); #1;
         if (!serial_tx) low_cnt++;
         if (busy) busy_cnt++;
      end
      checks++;
      if (low_cnt !== 0 || busy_cnt !== 0) begin
         errors++; $display("FAIL abort_no_resend got low=%0d busy=%0d want 0 0", low_cnt, busy_cnt);
      end
      start_byte(1'b1, 8'hC3, ok);
      capture(10 * D, 1'b0, 1'b0, w, bh, rh);
      checks++;
      if (!ok || w !== exp_wave(8'hC3, D) || bh !== 10 * D) begin
         errors++; $display("FAIL abort_fresh ok=%0d got=%h busy=%0d want=%h busy=%0d", ok, w, bh, exp_wave(8'hC3, D), 10 * D);
      end
      @(negedge clk); #1;
   endtask

   task automatic test_div1();
      logic [63:0] w; int bh, rh, t1;
      a1_valid = 1'b1; a1_data = 8'hA3; #1;
      checks++;
      if (a1_ready !== 1'b1) begin
         errors++; $display("FAIL div1_ready got=%b want=1", a1_ready);
      end
      t1 = cyc;
      @(negedge clk); #1; a1_data = 8'h5A;
      capture(10, 1'b1, 1'b0, w, bh, rh);
      checks++;
      if (w !== exp_wave(8'hA3, 1) || bh !== 10 || rh !== 0) begin
         errors++; $display("FAIL div1_wave got=%h busy=%0d ready=%0d want=%h busy=10 ready=0", w, bh, rh, exp_wave(8'hA3, 1));
      end
      @(negedge clk); #1;
      checks++;
      if (a1_ready !== 1'b1 || cyc - t1 !== 11) begin
         errors++; $display("FAIL div1_next got ready=%b gap=%0d want ready=1 gap=11", a1_ready, cyc - t1);
      end
      @(negedge clk); #1; a1_valid = 1'b0;
      repeat (12) @(negedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      a_valid = 1'b0; a_data = 8'h00; a_lock = 1'b0;
      b_valid = 1'b0; b_data = 8'h00; b_lock = 1'b0;
      a1_valid = 1'b0; a1_data = 8'h00; a1_lock = 1'b0;
      b1_valid = 1'b0; b1_data = 8'h00; b1_lock = 1'b0;
      test_reset();
      test_single_55();
      test_random_frames();
      test_tie();
      test_stream(1'b1, 1'b0, 3, 3);
      test_stream(1'b0, 1'b0, 3, 3);
      for (int r = 0; r < 3; r++)
         test_stream(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(1, 4), $urandom_range(1, 4));
      test_valid_drop();
      test_reset_midframe();
      test_div1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/risc8_uart_arb.md
RISC8_UART_ARB -- requirements
Module: risc8_uart_arb

Interface
REQ-001 SHALL have parameter DIVISOR, default 52, giving clk cycles per serial bit (6 MHz clk -> ~115200 baud); legal range 1..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 SHALL have ports a_valid input 1, a_data input 8, a_lock input 1, a_ready output 1: requester A byte channel.
REQ-005 SHALL have ports b_valid input 1, b_data input 8, b_lock input 1, b_ready output 1: requester B byte channel.
REQ-006 SHALL have port serial_tx  output  1  8N1 UART line, idle high.
REQ-007 SHALL have ports busy output 1 (frame in progress) and grant_a, grant_b outputs 1 each (owner of current frame).

Function
REQ-008 SHALL use a state machine with states IDLE, START, DATA, STOP.
REQ-009 In IDLE, SHALL select at most one requester and assert only its ready combinationally in the same cycle its valid is high; a byte transfers when valid and ready are both high.
REQ-010 Arbitration SHALL be round-robin per byte: if both are valid, the requester not recorded in last_grant wins.
REQ-011 If the last_grant requester has its lock high and valid high in IDLE, it SHALL win regardless of the other requester.
REQ-012 On transfer, SHALL latch the data byte, update last_grant, set grant_x (one-hot), and move to START on the next cycle.
REQ-013 Latency: serial_tx SHALL fall on the cycle after the transfer cycle.
REQ-014 START, each of 8 DATA bits (LSB first), and STOP SHALL each drive serial_tx for exactly DIVISOR cycles; STOP drives 1.
REQ-015 A frame SHALL occupy exactly 10*DIVISOR cycles from the first low cycle; IDLE SHALL then last at least one cycle before the next frame, so the minimum transfer-to-transfer spacing is 10*DIVISOR+1 cycles.
REQ-016 busy SHALL be high in START, DATA and STOP and low in IDLE; grant_x SHALL hold through the frame and clear on return to IDLE.
REQ-017 The baud counter SHALL load DIVISOR-1 on state or bit entry, decrement to 0, then advance; the bit index SHALL be 3 bits and wrap from 7 into STOP.
REQ-018 a_ready and b_ready SHALL be 0 outside IDLE; valid, data and lock changes during a frame SHALL have no effect on it.
REQ-019 A valid deasserted before ready SHALL cause no transfer and no change to last_grant.

Reset
REQ-020 While reset=0, SHALL force state=IDLE, serial_tx=1, busy=0, grant_a=grant_b=0, a_ready=b_ready=0, and last_grant=B, so A wins the first tie.
REQ-021 Reset asserted mid-frame SHALL abort the frame; serial_tx SHALL be 1 on the cycle after reset is sampled low, and the aborted byte SHALL NOT be resent.

Structure
REQ-022 State encoding constants, the last_grant encoding, and the default DIVISOR SHALL live in shared package risc8_uart_pkg.
REQ-023 The serializer (baud counter, bit index, shift register, serial_tx) SHALL be sub-module risc8_uart_tx with a load/busy handshake; risc8_uart_arb SHALL hold only arbitration and grant logic.

Verification (DIVISOR=4 unless stated)
REQ-024 After reset, A sends 0x55 alone -> a_ready high for 1 cycle; serial_tx = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total; busy high for 40 cycles.
REQ-025 A and B both valid in the same cycle after reset with A=0x01 and B=0x02 -> A transferred first, B in the next IDLE; transfer cycles are 41 apart.
REQ-026 A sends 3 bytes with a_lock=1 while B is continuously valid -> all 3 A bytes go first, then B; with a_lock=0 -> the order is A,B,A,B.
REQ-027 reset=0 during DATA bit 3 of 0x00 -> serial_tx=1, busy=0, grants=0 on the next cycle; the next transfer is a fresh frame.
REQ-028 DIVISOR=1, A sends 0xA3 -> serial_tx = 0,1,1,0,0,0,1,0,1,1, one cycle per bit; the next byte is accepted 11 cycles after the first.
